// File: rtl/console_pkg.sv
// Shared constants, types and row arithmetic for the text console.
package console_pkg;

  localparam int unsigned COLS    = 80;
  localparam int unsigned ROWS    = 60;
  localparam int unsigned CELL_W  = 20;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned X_W     = 7;
  localparam int unsigned Y_W     = 6;
  localparam int unsigned ADDR_W  = 13;

  localparam logic [CHAR_W-1:0] CH_BS = 8'h08;
  localparam logic [CHAR_W-1:0] CH_LF = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_FF = 8'h0C;
  localparam logic [CHAR_W-1:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_e;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [CHAR_W-1:0]  ascii;
  } cell_t;

  // (a + b) mod rows, summed one bit wider so it never wraps through 2^Y_W
  function automatic logic [Y_W-1:0] row_add(input logic [Y_W-1:0] a,
                                             input logic [Y_W-1:0] b,
                                             input int unsigned rows);
    logic [Y_W:0] s;
    s = (Y_W+1)'(a) + (Y_W+1)'(b);
    return (32'(s) >= rows) ? Y_W'(32'(s) - rows) : s[Y_W-1:0];
  endfunction

endpackage

// File: rtl/char_ram.sv
// Character cell storage: one synchronous write port, one asynchronous read port.
module char_ram
  import console_pkg::*;
#(
  parameter int unsigned DEPTH = COLS * ROWS,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = CELL_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read returns the pre-write value when a write to the same cell is pending
  assign rdata = mem[raddr];

endmodule

// File: rtl/text_console.sv
// Text console: character stream to a scrolling COLS x ROWS cell buffer read by the display.
module text_console #(
  parameter int unsigned COLS = console_pkg::COLS,
  parameter int unsigned ROWS = console_pkg::ROWS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ch_valid,
  input  logic [console_pkg::CHAR_W-1:0]          ch_data,
  input  logic [console_pkg::COLOR_W-1:0]         ch_color,
  output logic                                    ch_ready,
  input  logic [console_pkg::ADDR_W-1:0]          vga_addr,
  output logic [console_pkg::CELL_W-1:0]          vga_data,
  output logic [console_pkg::X_W-1:0]             cur_x,
  output logic [console_pkg::Y_W-1:0]             cur_y
);
  import console_pkg::*;

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  state_e            state, state_n;
  logic [AW-1:0]     cnt, cnt_n;
  logic [X_W-1:0]    x_n;
  logic [Y_W-1:0]    y_n, top, top_n;
  logic              nl;
  logic              we;
  logic [AW-1:0]     waddr, raddr;
  cell_t             wcell;
  logic [CELL_W-1:0] rdata;
  logic [X_W-1:0]    vx;
  logic [Y_W-1:0]    vy;
  logic              v_in;

  function automatic logic [AW-1:0] cell_addr(input logic [Y_W-1:0] prow,
                                              input logic [X_W-1:0] col);
    return AW'(32'(prow) * COLS + 32'(col));
  endfunction

  char_ram #(.DEPTH(CELLS), .AW(AW), .W(CELL_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wcell),
    .raddr (raddr),
    .rdata (rdata)
  );

  // State, cursor and scroll-origin registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLR_ALL;
      cnt      <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      top      <= '0;
      ch_ready <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_x    <= x_n;
      cur_y    <= y_n;
      top      <= top_n;
      ch_ready <= (state_n == IDLE);
    end
  end

  // Character decode, newline/scroll and clear sequencing
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = cur_x;
    y_n     = cur_y;
    top_n   = top;
    nl      = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wcell   = '0;
    unique case (state)
      IDLE: begin
        if (ch_valid && ch_ready) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            we    = 1'b1;
            waddr = cell_addr(row_add(cur_y, top, ROWS), cur_x);
            wcell = '{color: ch_color, ascii: ch_data};
            if (32'(cur_x) == COLS - 1) begin
              x_n = '0;
              nl  = 1'b1;
            end else begin
              x_n = cur_x + X_W'(1);
            end
          end else begin
            case (ch_data)
              CH_LF: begin
                x_n = '0;
                nl  = 1'b1;
              end
              CH_CR: x_n = '0;
              CH_BS: begin
                if (cur_x != '0) begin
                  x_n   = cur_x - X_W'(1);
                  we    = 1'b1;
                  waddr = cell_addr(row_add(cur_y, top, ROWS), cur_x - X_W'(1));
                end
              end
              CH_FF: begin
                state_n = CLR_ALL;
                cnt_n   = '0;
                x_n     = '0;
                y_n     = '0;
                top_n   = '0;
              end
              default: ;
            endcase
          end
          if (nl) begin
            if (32'(cur_y) < ROWS - 1) begin
              y_n = cur_y + Y_W'(1);
            end else begin
              top_n   = row_add(top, Y_W'(1), ROWS);
              state_n = CLR_LINE;
              cnt_n   = '0;
            end
          end
        end
      end
      CLR_LINE: begin
        // top already advanced, so the new bottom screen row sits at physical row top-1
        we    = 1'b1;
        waddr = cell_addr(row_add(Y_W'(ROWS - 1), top, ROWS), X_W'(cnt));
        if (32'(cnt) == COLS - 1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      CLR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        if (32'(cnt) == CELLS - 1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      default: state_n = CLR_ALL;
    endcase
  end

  // Display read path: out-of-range coordinates read as blank
  assign vx       = vga_addr[12:6];
  assign vy       = vga_addr[5:0];
  assign v_in     = (32'(vx) < COLS) && (32'(vy) < ROWS);
  assign raddr    = v_in ? cell_addr(row_add(vy, top, ROWS), vx) : '0;
  assign vga_data = v_in ? rdata : '0;

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameters: COLS, default 80, text columns; ROWS, default 60, text rows.
REQ-002 SHALL have port clk, input, 1, system clock; this is the pixel clock, 25 MHz.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ch_valid, input, 1, producer offers a character.
REQ-005 SHALL have port ch_data, input, 8, ASCII or control code.
REQ-006 SHALL have port ch_color, input, 12, colour as rrrr_gggg_bbbb.
REQ-007 SHALL have port ch_ready, output, 1, block can accept a character this cycle.
REQ-008 SHALL have port vga_addr, input, 13, display read address: x = [12:6], y = [5:0].
REQ-009 SHALL have port vga_data, output, 20, cell value as rrrr_gggg_bbbb_ascii.
REQ-010 SHALL have port cur_x, output, 7, cursor column.
REQ-011 SHALL have port cur_y, output, 6, cursor screen row.

Function
REQ-012 SHALL accept a character only when ch_valid and ch_ready are both 1 at a clk edge.
REQ-013 SHALL drive ch_ready = 1 only in state IDLE.
- States: IDLE, CLR_LINE, CLR_ALL.
REQ-014 SHALL handle printable codes 0x20-0x7E as follows:
- write {ch_color, ch_data} at (cur_x, cur_y) in the acceptance cycle;
- then increment cur_x;
- at cur_x == COLS-1, perform NEWLINE instead of incrementing.
REQ-015 SHALL handle 0x0A (LF) as: cur_x <= 0, then NEWLINE.
REQ-016 SHALL handle 0x0D (CR) as: cur_x <= 0 only.
REQ-017 SHALL handle 0x08 (BS) as follows:
- cur_x > 0: cur_x--, and the new cursor cell is written to 20'h0;
- cur_x == 0: no effect.
REQ-018 SHALL handle 0x0C (FF) as: enter CLR_ALL, cursor <= (0,0), top <= 0.
REQ-019 SHALL accept and ignore every other code, with no state change.
REQ-020 SHALL perform NEWLINE as follows:
- cur_y < ROWS-1: cur_y++;
- otherwise scroll: top <= (top+1) mod ROWS, cur_y stays ROWS-1, enter CLR_LINE.
REQ-021 SHALL map screen row y to physical row (y + top) mod ROWS, for both writes and reads.
REQ-022 SHALL, in CLR_LINE, write 20'h0 to one cell per cycle across the new bottom physical row, columns 0..COLS-1 (COLS cycles), then return to IDLE.
REQ-023 SHALL, in CLR_ALL, write 20'h0 to every cell, one per cycle (COLS*ROWS cycles), then return to IDLE.
REQ-024 SHALL provide vga_data combinationally from vga_addr, with zero latency, in every state.
REQ-025 SHALL return 20'h0 on vga_data for x >= COLS or y >= ROWS.
REQ-026 SHALL return the pre-write value on a same-cycle read and write of one cell; the new value appears from the next cycle.
REQ-027 SHALL make an accepted character visible on vga_data from the cycle after acceptance.
REQ-028 SHALL use mod-ROWS arithmetic for row addition, with no wrap through the 6-bit range.

Reset
REQ-029 SHALL force, while rst == 0: state CLR_ALL, clear counter 0, cur_x 0, cur_y 0, top 0, ch_ready 0.
REQ-030 SHALL, after rst rises, clear the whole buffer in COLS*ROWS cycles before ch_ready first goes to 1.
REQ-031 SHALL, on reset assertion mid-operation, abandon any clear in progress and restart from REQ-029.

Structure
REQ-032 SHALL place COLS, ROWS, cell width 20, and control codes LF/CR/BS/FF in shared package console_pkg.
REQ-033 SHALL use one sub-module, char_ram: COLS*ROWS x 20, one synchronous write port, one asynchronous read port.

Verification
REQ-034 SHALL cover reset then ch_ready: rst low then high -> ch_ready 0 for exactly 4800 cycles, then 1; every cell reads 20'h0.
REQ-035 SHALL cover a single write: write 'A' (0x41), colour FFF, at reset cursor -> vga_addr {7'd0,6'd0} reads 20'hFFF41 the next cycle; cur_x = 1.
REQ-036 SHALL cover line wrap: 80 printable characters from (0,0) -> cursor (0,1); the 80th character lands at x = 79, y = 0.
REQ-037 SHALL cover scroll: at cur_y = 59, send LF -> ch_ready low for 80 cycles; screen row 59 reads 0; old row 1 is now read at y = 0.
REQ-038 SHALL cover backspace and no-ops: BS at x = 0 -> no change; BS at x = 5 -> cur_x 4, cell (4,y) reads 0; code 0x07 -> no change.
REQ-039 SHALL cover reset mid-clear: rst low during CLR_LINE -> full 4800-cycle clear restarts; cursor at (0,0).
